sample_avg_fifo: RTL and testbench
==================================

Name: sample_avg_fifo

Overview:
Downstream consumer of the MCP3002 SPI leader's 8-bit sample word.
- Boxcar-averages 2^AVG_LOG2 consecutive samples and pushes each average into a first-word-fall-through FIFO.
- The FIFO is drained by the logging/transport stage (UART or memory writer) through a valid/ready port.
- Tracks dropped averages when the consumer stalls.

Parameters:
AVG_LOG2, 2, log2 of samples per average; legal range 0..4 (0 = pass-through, one sample per entry).
DEPTH_LOG2, 4, log2 of FIFO depth in entries (default 16).

Ports:
CLK_50MHz  input  1  sole clock; every register in the block is on its rising edge.
RESET  input  1  synchronous, active-high reset.
Log_enable  input  1  high = capture samples; low = accumulator held clear and no strobes accepted.
Sample_in  input  8  sample word from the ADC stage; must be stable while Sample_strobe is high.
Sample_strobe  input  1  one-cycle pulse in the CLK_50MHz domain marking a new Sample_in.
Rd_data  output  8  FIFO head average; meaningful only while Rd_valid is high.
Rd_valid  output  1  FIFO non-empty.
Rd_ready  input  1  consumer accepts; pop occurs on a cycle where Rd_valid && Rd_ready.
Fill_level  output  DEPTH_LOG2+1  current number of FIFO entries, 0..2^DEPTH_LOG2.
Overflow  output  1  sticky; set when an average is dropped because the FIFO is full.
Drop_count  output  8  number of dropped averages; saturates at 255.
Clear_overflow  input  1  one-cycle pulse that clears Overflow and Drop_count.

Behaviour:
- Reset (RESET high at a clock edge), applied in the same cycle:
  - State = IDLE; accumulator = 0; sample count = 0.
  - FIFO emptied: Rd_valid=0, Fill_level=0, Rd_data=0.
  - Overflow=0, Drop_count=0.
  - Reset mid-average discards the partial sum.
  - Reset with a full FIFO discards all entries; nothing is popped.
- Accumulator: width 8+AVG_LOG2, so it never overflows.
  - Average = accumulator >> AVG_LOG2, truncated with no rounding; always 8 bits.
- State machine:
  - IDLE: entered from reset or whenever Log_enable=0. Accumulator and count are held at 0. Goes to ACCUM when Log_enable=1.
  - ACCUM: on each Sample_strobe, accumulator += Sample_in and count += 1.
    - The strobe carrying the 2^AVG_LOG2-th sample goes to WRITE, with the final sum including that sample.
    - Log_enable falling in ACCUM goes to IDLE and discards the partial sum.
  - WRITE: lasts exactly one cycle.
    - Pushes the average if the FIFO is not full; otherwise drops it, sets Overflow, and increments Drop_count (saturating).
    - Clears accumulator and count, then returns to ACCUM, or to IDLE if Log_enable=0.
    - A Sample_strobe arriving during WRITE is accepted as the first sample of the next average: accumulator loads Sample_in, count = 1.
- Latency:
  - Push happens in the cycle after the final strobe.
  - Rd_valid rises and Rd_data is valid on the following cycle, i.e. two cycles after the final strobe.
- FIFO:
  - FWFT: Rd_data shows the head while Rd_valid=1 and holds stable until popped.
  - Pointers wrap modulo 2^DEPTH_LOG2.
- FIFO boundary conditions:
  - Push and pop in the same cycle when full: both succeed, Fill_level is unchanged, nothing is dropped.
  - Push and pop in the same cycle when empty: pop is impossible (Rd_valid=0), so only the push takes effect.
  - Pop while empty is ignored.
- Clear_overflow coinciding with a drop: the clear wins, leaving Overflow=0 and Drop_count=0.
- Sample rate: the upstream rate is much lower (about 1 strobe per 16 SPI clocks), so back-to-back strobes are not required. The block must nevertheless handle a strobe on every cycle correctly.

Decomposition:
- Shared package (adc_logger_pkg):
  - SAMPLE_W=8 constant.
  - State enum {IDLE, ACCUM, WRITE}.
  - Default AVG_LOG2 and DEPTH_LOG2 constants.
  - Saturating-increment width constant for drop counters (8).
- One sub-module, sync_fifo_fwft (parameters WIDTH, DEPTH_LOG2):
  - Owns pointers, count, storage, and the push/pop/full/empty logic.
  - Reused later by the transport stage.
- The averaging FSM and overflow tracking stay in sample_avg_fifo.

Test Plan:
- Basic average: AVG_LOG2=2, Rd_ready=1, strobes with Sample_in 10,20,30,41 -> one entry of 25 (sum 101 >> 2); Rd_valid is high for exactly one cycle, two cycles after the 4th strobe.
- Truncation and extremes: four samples of 255 -> 255; samples 0,0,0,3 -> 0; AVG_LOG2=0 with 0x5A -> 0x5A.
- Fill and overflow: Rd_ready=0, DEPTH_LOG2=4, 18 full averages -> Fill_level=16, Overflow=1, Drop_count=2; then Clear_overflow -> both 0, and draining returns the first 16 averages in order.
- Full with simultaneous push/pop: FIFO full, Rd_ready=1 in the same cycle as WRITE -> Fill_level stays 16, Drop_count unchanged, head advances.
- Disable and reset mid-operation: 2 of 4 samples, then Log_enable=0 for 1 cycle, then 4 samples of 100 -> single entry of 100. Separately, RESET during ACCUM with 5 entries queued -> Rd_valid=0 and Fill_level=0 the next cycle.
- Strobe during WRITE: strobes on consecutive cycles with 8 samples of value 8 -> exactly two entries of 8, no sample lost.

Source files
------------

// File: rtl/adc_logger_pkg.sv
// Shared constants and types for the ADC logging path: sample width,
// averaging FSM states and default sizing.
package adc_logger_pkg;

  localparam int SAMPLE_W       = 8;
  localparam int AVG_LOG2_DEF   = 2;
  localparam int DEPTH_LOG2_DEF = 4;
  localparam int DROP_CNT_W     = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    WRITE = 2'd2
  } avg_state_t;

endpackage

// File: rtl/sync_fifo_fwft.sv
// Single-clock first-word-fall-through FIFO; the head word is presented
// combinationally whenever the FIFO holds at least one entry.
module sync_fifo_fwft #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [WIDTH-1:0]      wr_data,
  input  logic                  pop,
  output logic [WIDTH-1:0]      rd_data,
  output logic                  rd_valid,
  output logic                  full,
  output logic [DEPTH_LOG2:0]   level
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] DEPTH_CNT = (DEPTH_LOG2 + 1)'(DEPTH);

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [DEPTH_LOG2:0]   count;
  logic                  do_push;
  logic                  do_pop;

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  always_comb begin
    do_pop   = pop && (count != '0);
    do_push  = push && ((count != DEPTH_CNT) || do_pop);
    rd_valid = (count != '0);
    full     = (count == DEPTH_CNT);
    level    = count;
    rd_data  = rd_valid ? mem[rd_ptr] : '0;
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
      if (do_pop)  rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (DEPTH_LOG2 + 1)'(1);
        2'b01:   count <= count - (DEPTH_LOG2 + 1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/sample_avg_fifo.sv
// Boxcar-averages 2^AVG_LOG2 ADC samples and queues each average in a FWFT
// FIFO; averages that find the FIFO full are counted as drops.
module sample_avg_fifo
  import adc_logger_pkg::*;
#(
  parameter int AVG_LOG2   = AVG_LOG2_DEF,
  parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF
) (
  input  logic                  CLK_50MHz,
  input  logic                  RESET,
  input  logic                  Log_enable,
  input  logic [SAMPLE_W-1:0]   Sample_in,
  input  logic                  Sample_strobe,
  output logic [SAMPLE_W-1:0]   Rd_data,
  output logic                  Rd_valid,
  input  logic                  Rd_ready,
  output logic [DEPTH_LOG2:0]   Fill_level,
  output logic                  Overflow,
  output logic [DROP_CNT_W-1:0] Drop_count,
  input  logic                  Clear_overflow
);

  localparam int ACC_W = SAMPLE_W + AVG_LOG2;
  localparam int CNT_W = AVG_LOG2 + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(2 ** AVG_LOG2);

  avg_state_t          state_q, state_d;
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                take;
  logic                done;
  logic                wr_push;
  logic [SAMPLE_W-1:0] avg;
  logic                fifo_full;
  logic                drop;

  function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] v);
    return (&v) ? v : v + DROP_CNT_W'(1);
  endfunction

  always_ff @(posedge CLK_50MHz) begin
    if (RESET) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
    end
  end

  // WRITE starts a fresh sum, so a strobe landing there becomes sample one.
  always_comb begin
    take  = Log_enable && Sample_strobe && (state_q != IDLE);
    acc_d = (state_q == WRITE) ? '0 : acc_q;
    cnt_d = (state_q == WRITE) ? '0 : cnt_q;
    if (take) begin
      acc_d = acc_d + ACC_W'(Sample_in);
      cnt_d = cnt_d + CNT_W'(1);
    end
    if (!Log_enable) begin
      acc_d = '0;
      cnt_d = '0;
    end
    done = take && (cnt_d == CNT_LAST);
  end

  always_comb begin
    state_d = state_q;
    if (!Log_enable) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    state_d = ACCUM;
        ACCUM:   state_d = done ? WRITE : ACCUM;
        WRITE:   state_d = done ? WRITE : ACCUM;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    wr_push = (state_q == WRITE);
    avg     = acc_q[AVG_LOG2 +: SAMPLE_W];
    drop    = wr_push && fifo_full && !(Rd_valid && Rd_ready);
  end

  sync_fifo_fwft #(
    .WIDTH      (SAMPLE_W),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .clk      (CLK_50MHz),
    .rst      (RESET),
    .push     (wr_push),
    .wr_data  (avg),
    .pop      (Rd_ready),
    .rd_data  (Rd_data),
    .rd_valid (Rd_valid),
    .full     (fifo_full),
    .level    (Fill_level)
  );

  // Clear takes priority over a drop in the same cycle.
  always_ff @(posedge CLK_50MHz) begin
    if (RESET || Clear_overflow) begin
      Overflow   <= 1'b0;
      Drop_count <= '0;
    end else if (drop) begin
      Overflow   <= 1'b1;
      Drop_count <= sat_inc(Drop_count);
    end
  end

endmodule

// File: tb/tb_sample_avg_fifo.sv
// Directed bench for sample_avg_fifo: averaging, FIFO fill/overflow,
// boundary push/pop, disable/reset mid-average and back-to-back strobes.
module tb_sample_avg_fifo;

  logic       clk = 1'b0;
  logic       RESET;
  logic       Log_enable;
  logic [7:0] Sample_in;
  logic       Sample_strobe;
  logic       Rd_ready;
  logic       Clear_overflow;

  logic [7:0] Rd_data;
  logic       Rd_valid;
  logic [4:0] Fill_level;
  logic       Overflow;
  logic [7:0] Drop_count;

  logic [7:0] p_Rd_data;
  logic       p_Rd_valid;
  logic [4:0] p_Fill_level;
  logic       p_Overflow;
  logic [7:0] p_Drop_count;

  int errors = 0;
  int checks = 0;

  always #10 clk = ~clk;

  sample_avg_fifo #(.AVG_LOG2(2), .DEPTH_LOG2(4)) dut (
    .CLK_50MHz      (clk),
    .RESET          (RESET),
    .Log_enable     (Log_enable),
    .Sample_in      (Sample_in),
    .Sample_strobe  (Sample_strobe),
    .Rd_data        (Rd_data),
    .Rd_valid       (Rd_valid),
    .Rd_ready       (Rd_ready),
    .Fill_level     (Fill_level),
    .Overflow       (Overflow),
    .Drop_count     (Drop_count),
    .Clear_overflow (Clear_overflow)
  );

  sample_avg_fifo #(.AVG_LOG2(0), .DEPTH_LOG2(4)) dut_pass (
    .CLK_50MHz      (clk),
    .RESET          (RESET),
    .Log_enable     (Log_enable),
    .Sample_in      (Sample_in),
    .Sample_strobe  (Sample_strobe),
    .Rd_data        (p_Rd_data),
    .Rd_valid       (p_Rd_valid),
    .Rd_ready       (Rd_ready),
    .Fill_level     (p_Fill_level),
    .Overflow       (p_Overflow),
    .Drop_count     (p_Drop_count),
    .Clear_overflow (Clear_overflow)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    RESET          = 1'b1;
    Log_enable     = 1'b1;
    Sample_strobe  = 1'b0;
    Sample_in      = 8'd0;
    Clear_overflow = 1'b0;
    tick();
    RESET = 1'b0;
    tick();
  endtask

  task automatic strobe(input logic [7:0] v);
    Sample_in     = v;
    Sample_strobe = 1'b1;
    tick();
    Sample_strobe = 1'b0;
  endtask

  // Four strobes of one value; returns in the WRITE cycle.
  task automatic strobe4(input logic [7:0] v);
    for (int k = 0; k < 4; k++) strobe(v);
  endtask

  task automatic test_reset();
    Rd_ready = 1'b0;
    do_reset();
    checks++; if (Rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_valid got=%0d want=0", Rd_valid); end
    checks++; if (Fill_level !== 5'd0) begin errors++; $display("FAIL reset_fill got=%0d want=0", Fill_level); end
    checks++; if (Rd_data !== 8'd0) begin errors++; $display("FAIL reset_rd_data got=%0d want=0", Rd_data); end
    checks++; if (Overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got=%0d want=0", Overflow); end
    checks++; if (Drop_count !== 8'd0) begin errors++; $display("FAIL reset_drop got=%0d want=0", Drop_count); end
  endtask

  task automatic test_basic_avg();
    do_reset();
    Rd_ready = 1'b1;
    strobe(8'd10); tick();
    strobe(8'd20); tick();
    strobe(8'd30); tick();
    strobe(8'd41);
    checks++; if (Rd_valid !== 1'b0) begin errors++; $display("FAIL basic_early_valid got=%0d want=0", Rd_valid); end
    tick();
    checks++; if (Rd_valid !== 1'b1) begin errors++; $display("FAIL basic_valid got=%0d want=1", Rd_valid); end
    checks++; if (Rd_data !== 8'd25) begin errors++; $display("FAIL basic_data got=%0d want=25", Rd_data); end
    tick();
    checks++; if (Rd_valid !== 1'b0) begin errors++; $display("FAIL basic_one_cycle got=%0d want=0", Rd_valid); end
  endtask

  task automatic test_extremes();
    do_reset();
    Rd_ready = 1'b1;
    strobe4(8'd255); tick();
    checks++; if (Rd_valid !== 1'b1 || Rd_data !== 8'd255) begin errors++; $display("FAIL max_avg got=%0d/%0d want=1/255", Rd_valid, Rd_data); end
    tick();
    strobe(8'd0); strobe(8'd0); strobe(8'd0); strobe(8'd3); tick();
    checks++; if (Rd_valid !== 1'b1 || Rd_data !== 8'd0) begin errors++; $display("FAIL trunc_avg got=%0d/%0d want=1/0", Rd_valid, Rd_data); end
    tick();
  endtask

  task automatic test_passthrough();
    Rd_ready = 1'b0;
    do_reset();
    strobe(8'h5A); tick();
    checks++; if (p_Rd_valid !== 1'b1 || p_Rd_data !== 8'h5A) begin errors++; $display("FAIL pass_data got=%0d/%h want=1/5a", p_Rd_valid, p_Rd_data); end
    checks++; if (p_Fill_level !== 5'd1) begin errors++; $display("FAIL pass_fill got=%0d want=1", p_Fill_level); end
  endtask

  task automatic test_fill_overflow();
    Rd_ready = 1'b0;
    do_reset();
    for (int i = 0; i < 18; i++) begin
      strobe4(8'(i + 1));
      tick();
    end
    checks++; if (Fill_level !== 5'd16) begin errors++; $display("FAIL ovf_fill got=%0d want=16", Fill_level); end
    checks++; if (Overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got=%0d want=1", Overflow); end
    checks++; if (Drop_count !== 8'd2) begin errors++; $display("FAIL ovf_drops got=%0d want=2", Drop_count); end
    Clear_overflow = 1'b1; tick(); Clear_overflow = 1'b0;
    checks++; if (Overflow !== 1'b0 || Drop_count !== 8'd0) begin errors++; $display("FAIL ovf_clear got=%0d/%0d want=0/0", Overflow, Drop_count); end
    Rd_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (Rd_valid !== 1'b1 || Rd_data !== 8'(i + 1)) begin
        errors++; $display("FAIL drain_%0d got=%0d/%0d want=1/%0d", i, Rd_valid, Rd_data, i + 1);
      end
      tick();
    end
    checks++; if (Fill_level !== 5'd0) begin errors++; $display("FAIL drain_empty got=%0d want=0", Fill_level); end
    Rd_ready = 1'b0;
  endtask

  task automatic test_full_push_pop();
    Rd_ready = 1'b0;
    do_reset();
    for (int i = 0; i < 16; i++) begin
      strobe4(8'(i + 1));
      tick();
    end
    strobe4(8'd200);
    Rd_ready = 1'b1; tick(); Rd_ready = 1'b0;
    checks++; if (Fill_level !== 5'd16) begin errors++; $display("FAIL pp_fill got=%0d want=16", Fill_level); end
    checks++; if (Drop_count !== 8'd0 || Overflow !== 1'b0) begin errors++; $display("FAIL pp_nodrop got=%0d/%0d want=0/0", Overflow, Drop_count); end
    checks++; if (Rd_data !== 8'd2) begin errors++; $display("FAIL pp_head got=%0d want=2", Rd_data); end
    strobe4(8'd77); tick();
    checks++; if (Overflow !== 1'b1 || Drop_count !== 8'd1) begin errors++; $display("FAIL pp_drop got=%0d/%0d want=1/1", Overflow, Drop_count); end
    strobe4(8'd78);
    Clear_overflow = 1'b1; tick(); Clear_overflow = 1'b0;
    checks++; if (Overflow !== 1'b0 || Drop_count !== 8'd0) begin errors++; $display("FAIL clear_wins got=%0d/%0d want=0/0", Overflow, Drop_count); end
  endtask

  task automatic test_disable_mid();
    Rd_ready = 1'b0;
    do_reset();
    strobe(8'd50); strobe(8'd60);
    Log_enable = 1'b0; tick();
    Log_enable = 1'b1; tick();
    strobe4(8'd100); tick();
    checks++; if (Fill_level !== 5'd1) begin errors++; $display("FAIL dis_fill got=%0d want=1", Fill_level); end
    checks++; if (Rd_data !== 8'd100) begin errors++; $display("FAIL dis_data got=%0d want=100", Rd_data); end
  endtask

  task automatic test_reset_mid();
    Rd_ready = 1'b0;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      strobe4(8'(i + 1));
      tick();
    end
    strobe(8'd9); strobe(8'd9);
    checks++; if (Fill_level !== 5'd5) begin errors++; $display("FAIL rst_pre_fill got=%0d want=5", Fill_level); end
    RESET = 1'b1; tick(); RESET = 1'b0;
    checks++; if (Rd_valid !== 1'b0 || Fill_level !== 5'd0) begin errors++; $display("FAIL rst_mid got=%0d/%0d want=0/0", Rd_valid, Fill_level); end
  endtask

  task automatic test_back_to_back();
    Rd_ready = 1'b0;
    do_reset();
    Sample_in = 8'd8;
    Sample_strobe = 1'b1;
    for (int k = 0; k < 8; k++) tick();
    Sample_strobe = 1'b0;
    tick(); tick();
    checks++; if (Fill_level !== 5'd2) begin errors++; $display("FAIL b2b_fill got=%0d want=2", Fill_level); end
    Rd_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (Rd_valid !== 1'b1 || Rd_data !== 8'd8) begin
        errors++; $display("FAIL b2b_data_%0d got=%0d/%0d want=1/8", k, Rd_valid, Rd_data);
      end
      tick();
    end
    checks++; if (Rd_valid !== 1'b0) begin errors++; $display("FAIL b2b_empty got=%0d want=0", Rd_valid); end
    Rd_ready = 1'b0;
  endtask

  initial begin
    RESET = 1'b1; Log_enable = 1'b0; Sample_in = 8'd0; Sample_strobe = 1'b0;
    Rd_ready = 1'b0; Clear_overflow = 1'b0;
    test_reset();
    test_basic_avg();
    test_extremes();
    test_passthrough();
    test_fill_overflow();
    test_full_push_pop();
    test_disable_mid();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
